// File: rtl/sdram_arb2.sv
// Two-client round-robin arbiter in front of a toggle-handshake SDRAM controller.
// Each client owns a single pending slot; one transaction is in flight at a time.
module sdram_arb2 (
    input  logic        clk,
    input  logic        init_n,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [20:0] c0_a,
    input  logic [1:0]  c0_ds,
    input  logic [15:0] c0_d,
    output logic        c0_busy,
    output logic        c0_valid,
    output logic [15:0] c0_q,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [20:0] c1_a,
    input  logic [1:0]  c1_ds,
    input  logic [15:0] c1_d,
    output logic        c1_busy,
    output logic        c1_valid,
    output logic [15:0] c1_q,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [20:0] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q
);

    typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

    state_t      state_q, state_d;

    // Per-client request inputs gathered into indexable form
    logic [1:0]  in_req;
    logic [1:0]  in_we;
    logic [20:0] in_a  [2];
    logic [1:0]  in_ds [2];
    logic [15:0] in_d  [2];

    // Pending slots, one per client
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  swe_q, swe_d;
    logic [20:0] sa_q  [2];
    logic [20:0] sa_d  [2];
    logic [1:0]  sds_q [2];
    logic [1:0]  sds_d [2];
    logic [15:0] sd_q  [2];
    logic [15:0] sd_d  [2];

    // Client-facing results
    logic [15:0] cq_q  [2];
    logic [15:0] cq_d  [2];
    logic [1:0]  valid_q, valid_d;

    // Arbitration bookkeeping: who was served last, who is in flight now
    logic        last_q, last_d;
    logic        grant_q, grant_d;
    logic        gsel;

    // Controller-facing registers
    logic        mreq_q, mreq_d;
    logic        mwe_q, mwe_d;
    logic [20:0] ma_q, ma_d;
    logic [1:0]  mds_q, mds_d;
    logic [15:0] md_q, md_d;

    assign in_req   = {c1_req, c0_req};
    assign in_we    = {c1_we, c0_we};
    assign in_a[0]  = c0_a;
    assign in_a[1]  = c1_a;
    assign in_ds[0] = c0_ds;
    assign in_ds[1] = c1_ds;
    assign in_d[0]  = c0_d;
    assign in_d[1]  = c1_d;

    // Lone pending slot wins outright; on a tie the client not served last wins
    assign gsel = (pend_q == 2'b11) ? ~last_q : ~pend_q[0];

    assign c0_busy  = pend_q[0];
    assign c1_busy  = pend_q[1];
    assign c0_valid = valid_q[0];
    assign c1_valid = valid_q[1];
    assign c0_q     = cq_q[0];
    assign c1_q     = cq_q[1];
    assign mem_req  = mreq_q;
    assign mem_we   = mwe_q;
    assign mem_a    = ma_q;
    assign mem_ds   = mds_q;
    assign mem_d    = md_q;

    // Next-state logic: slot capture, issue on IDLE, completion on WAIT
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        swe_d   = swe_q;
        for (int i = 0; i < 2; i++) begin
            sa_d[i]  = sa_q[i];
            sds_d[i] = sds_q[i];
            sd_d[i]  = sd_q[i];
            cq_d[i]  = cq_q[i];
        end
        valid_d = 2'b00;
        last_d  = last_q;
        grant_d = grant_q;
        mreq_d  = mreq_q;
        mwe_d   = mwe_q;
        ma_d    = ma_q;
        mds_d   = mds_q;
        md_d    = md_q;

        // A busy client's strobe is ignored, including on its completion edge
        for (int i = 0; i < 2; i++) begin
            if (in_req[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                swe_d[i]  = in_we[i];
                sa_d[i]   = in_a[i];
                sds_d[i]  = in_ds[i];
                sd_d[i]   = in_d[i];
            end
        end

        case (state_q)
            SYNC: begin
                // Align the toggle pair with whatever level the controller holds
                mreq_d  = mem_ack;
                state_d = IDLE;
            end
            IDLE: begin
                if (|pend_q) begin
                    mwe_d   = swe_q[gsel];
                    ma_d    = sa_q[gsel];
                    mds_d   = sds_q[gsel];
                    md_d    = sd_q[gsel];
                    mreq_d  = ~mreq_q;
                    grant_d = gsel;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack == mreq_q) begin
                    pend_d[grant_q]  = 1'b0;
                    valid_d[grant_q] = 1'b1;
                    if (!swe_q[grant_q]) begin
                        cq_d[grant_q] = mem_q;
                    end
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: slots, results, arbitration and controller drive
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            pend_q  <= 2'b00;
            swe_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                sa_q[i]  <= '0;
                sds_q[i] <= 2'b11;
                sd_q[i]  <= '0;
                cq_q[i]  <= '0;
            end
            valid_q <= 2'b00;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            ma_q    <= '0;
            mds_q   <= 2'b11;
            md_q    <= '0;
        end else begin
            pend_q  <= pend_d;
            swe_q   <= swe_d;
            for (int i = 0; i < 2; i++) begin
                sa_q[i]  <= sa_d[i];
                sds_q[i] <= sds_d[i];
                sd_q[i]  <= sd_d[i];
                cq_q[i]  <= cq_d[i];
            end
            valid_q <= valid_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
            ma_q    <= ma_d;
            mds_q   <= mds_d;
            md_q    <= md_d;
        end
    end

endmodule
